// File: rtl/regfile_read_arbiter_if.sv
// Read-port bundle between the requesters/register file and the read arbiter.
// The master side drives requests, write-forwarding data and the mux output.
interface regfile_read_arbiter_if #(
  parameter int DW = 64,
  parameter int AW = 5
);
  logic          req_a;
  logic [AW-1:0] addr_a;
  logic          gnt_a;
  logic          rvalid_a;
  logic          req_b;
  logic [AW-1:0] addr_b;
  logic          gnt_b;
  logic          rvalid_b;
  logic [AW-1:0] rsel;
  logic [DW-1:0] rdata_in;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] rdata;

  modport master (
    output req_a, addr_a, req_b, addr_b, rdata_in, wr_en, wr_addr, wr_data,
    input  gnt_a, rvalid_a, gnt_b, rvalid_b, rsel, rdata
  );

  modport slave (
    input  req_a, addr_a, req_b, addr_b, rdata_in, wr_en, wr_addr, wr_data,
    output gnt_a, rvalid_a, gnt_b, rvalid_b, rsel, rdata
  );
endinterface

// File: rtl/regfile_read_arbiter.sv
// Round-robin arbiter sharing one register-file read port between the decode
// stage (A) and the debug port (B), with write forwarding and a zero register.
module regfile_read_arbiter #(
  parameter int DW       = 64,
  parameter int AW       = 5,
  parameter int ZERO_REG = 31
) (
  input logic                  clk,
  input logic                  reset,
  regfile_read_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_A = 2'd1,
    SERVE_B = 2'd2
  } state_t;

  localparam logic [AW-1:0] ZERO_IDX = AW'(ZERO_REG);

  state_t        state;
  state_t        state_next;
  logic          last_b;
  logic          gnt_a;
  logic          gnt_b;
  logic [AW-1:0] rsel;
  logic [DW-1:0] read_value;
  logic [DW-1:0] rdata;

  // On a tie the requester that did not win last time takes the port.
  always_comb begin
    gnt_a = bus.req_a && (!bus.req_b || last_b);
    gnt_b = bus.req_b && (!bus.req_a || !last_b);
    rsel  = '0;
    if (gnt_a) begin
      rsel = bus.addr_a;
    end else if (gnt_b) begin
      rsel = bus.addr_b;
    end
  end

  // The zero register wins over forwarding, so writes to it are never seen.
  always_comb begin
    read_value = bus.rdata_in;
    if (rsel == ZERO_IDX) begin
      read_value = '0;
    end else if (bus.wr_en && (bus.wr_addr == rsel)) begin
      read_value = bus.wr_data;
    end
  end

  always_comb begin
    state_next = IDLE;
    if (gnt_a) begin
      state_next = SERVE_A;
    end else if (gnt_b) begin
      state_next = SERVE_B;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      last_b <= 1'b1;
      rdata  <= '0;
    end else begin
      state <= state_next;
      if (gnt_a || gnt_b) begin
        last_b <= gnt_b;
        rdata  <= read_value;
      end
    end
  end

  assign bus.gnt_a    = gnt_a;
  assign bus.gnt_b    = gnt_b;
  assign bus.rsel     = rsel;
  assign bus.rdata    = rdata;
  assign bus.rvalid_a = (state == SERVE_A);
  assign bus.rvalid_b = (state == SERVE_B);

  // A waiting requester must keep its address stable until it is granted.
  a_addr_a_stable: assert property (@(posedge clk) disable iff (reset)
    (bus.req_a && !gnt_a) |=> (!bus.req_a || $stable(bus.addr_a)));
  a_addr_b_stable: assert property (@(posedge clk) disable iff (reset)
    (bus.req_b && !gnt_b) |=> (!bus.req_b || $stable(bus.addr_b)));
  a_one_grant: assert property (@(posedge clk) disable iff (reset)
    !(gnt_a && gnt_b));

endmodule
